// File: rtl/dcache_pkg.sv
// dcache_pkg: shared field widths, FSM encoding and address-slice helpers for the data cache
package dcache_pkg;
  localparam int NUM_LINES = 8;
  localparam int INDEX_BITS = 3;
  localparam int OFFSET_BITS = 2;
  localparam int TAG_BITS = 8 - INDEX_BITS - OFFSET_BITS;
  typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, FETCH = 2'd2, UPDATE = 2'd3} state_t;
  typedef logic [TAG_BITS-1:0] tag_t;
  typedef logic [INDEX_BITS-1:0] index_t;
  typedef logic [OFFSET_BITS-1:0] offset_t;
  function automatic tag_t addr_tag(input logic [7:0] a);
    return a[7:5];
  endfunction
  function automatic index_t addr_index(input logic [7:0] a);
    return a[4:2];
  endfunction
  function automatic offset_t addr_offset(input logic [7:0] a);
    return a[1:0];
  endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: CPU-side and memory-side signals of the data cache
interface dcache_if;
  logic read, write, busywait;
  logic [7:0] address, writedata, readdata;
  logic mem_read, mem_write, mem_busywait;
  logic [5:0] mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  modport slave (
    input read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_line_array.sv
// dcache_line_array: valid/dirty/tag/data storage with a combinational read port, byte write and block fill
module dcache_line_array
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  index_t      idx,
  output logic        rd_valid,
  output logic        rd_dirty,
  output tag_t        rd_tag,
  output logic [31:0] rd_data,
  input  logic        byte_we,
  input  offset_t     byte_off,
  input  logic [7:0]  byte_data,
  input  logic        fill_we,
  input  tag_t        fill_tag,
  input  logic [31:0] fill_data
);
  logic [NUM_LINES-1:0] valid, dirty;
  tag_t tags [NUM_LINES];
  logic [31:0] data [NUM_LINES];
  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag = tags[idx];
  assign rd_data = data[idx];
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_we) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (byte_we) dirty[idx] <= 1'b1;
  end
  // tags and data survive reset; writes are only suppressed while it is held
  always_ff @(posedge clk) begin
    if (reset && fill_we) begin
      tags[idx] <= fill_tag;
      data[idx] <= fill_data;
    end else if (reset && byte_we) data[idx][8*byte_off +: 8] <= byte_data;
  end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate cache FSM, hit compare and memory-port muxing
module dcache_ctrl
  import dcache_pkg::*;
(
  input logic clk,
  input logic reset,
  dcache_if.slave bus
);
  state_t state, next;
  logic v, d, req, hit;
  tag_t st;
  logic [31:0] line, fill_q;
  logic [7:0] rd_q, sel;
  assign req = bus.read | bus.write;
  assign hit = v && st == addr_tag(bus.address);
  assign sel = line[8*addr_offset(bus.address) +: 8];
  dcache_line_array u_lines (
    .clk(clk),
    .reset(reset),
    .idx(addr_index(bus.address)),
    .rd_valid(v),
    .rd_dirty(d),
    .rd_tag(st),
    .rd_data(line),
    .byte_we(state == IDLE && bus.write && hit),
    .byte_off(addr_offset(bus.address)),
    .byte_data(bus.writedata),
    .fill_we(state == UPDATE),
    .fill_tag(addr_tag(bus.address)),
    .fill_data(fill_q)
  );
  always_ff @(posedge clk) state <= !reset ? IDLE : next;
  always_comb begin
    next = state == IDLE ? (req && !hit ? (v && d ? WRITEBACK : FETCH) : IDLE) :
           state == WRITEBACK ? (bus.mem_busywait ? WRITEBACK : FETCH) :
           state == FETCH ? (bus.mem_busywait ? FETCH : UPDATE) : IDLE;
  end
  always_comb begin
    bus.busywait = state != IDLE || (req && !hit);
    bus.mem_write = state == WRITEBACK;
    bus.mem_read = state == FETCH;
    bus.mem_address = state == WRITEBACK ? {st, addr_index(bus.address)} :
                      state == FETCH ? {addr_tag(bus.address), addr_index(bus.address)} : '0;
    bus.mem_writedata = state == WRITEBACK ? line : '0;
    bus.readdata = state == IDLE && req && hit ? sel : rd_q;
  end
  // rd_q keeps the last load result visible when the CPU is not requesting
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q <= '0;
      fill_q <= '0;
    end else begin
      rd_q <= bus.readdata;
      if (state == FETCH && !bus.mem_busywait) fill_q <= bus.mem_readdata;
    end
  end
endmodule
